// File: rtl/fetch_decode_queue.sv
// -----------------------------------------------------------------------------
// fetch_decode_queue
//
// Instruction buffer between fetch and decode. Fetch pushes
// {instruction, pc, pc_plus4} into a DEPTH-entry circular FIFO and decode
// consumes the oldest entry over a valid/ready handshake. A redirect flush
// discards everything buffered plus whatever fetch offers in that cycle.
//
// Optional feature (macro FETCH_DECODE_QUEUE_BYPASS_EN): when the queue is
// empty, the incoming instruction is forwarded straight to decode in the same
// cycle; if decode takes it, it is never written into storage.
//
// Ports:
//   i_clk          clock, all state updates on the rising edge
//   i_rst_n        synchronous active-low reset
//   i_instruction  instruction from fetch
//   i_pc           PC of i_instruction
//   i_pc_plus4     PC+4 of i_instruction
//   i_valid        fetch presents a valid instruction
//   o_ready        queue accepts a push this cycle (registered state only)
//   i_flush        redirect: drop all entries and the incoming push
//   o_instruction  head-entry instruction
//   o_pc           head-entry PC
//   o_pc_plus4     head-entry PC+4
//   o_valid        head entry valid
//   i_ready        decode accepts the head entry this cycle
//   o_count        number of occupied entries
// -----------------------------------------------------------------------------
module fetch_decode_queue #(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [INSTR_WIDTH-1:0]   i_instruction,
  input  logic [ADDR_WIDTH-1:0]    i_pc,
  input  logic [ADDR_WIDTH-1:0]    i_pc_plus4,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_flush,
  output logic [INSTR_WIDTH-1:0]   o_instruction,
  output logic [ADDR_WIDTH-1:0]    o_pc,
  output logic [ADDR_WIDTH-1:0]    o_pc_plus4,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [INSTR_WIDTH-1:0] instr_q [DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_q    [DEPTH];
  logic [ADDR_WIDTH-1:0]  pc4_q   [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic empty;
  logic push;
  logic pop;
  logic bypass;
  logic wr_en;
  logic rd_adv;

  assign empty   = (count_q == '0);
  // Derived from the registered count only, so a pop never opens o_ready
  // in the same cycle and there is no i_ready -> o_ready path.
  assign o_ready = (count_q != FULL_COUNT);
  assign push    = i_valid & o_ready & ~i_flush;

`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
  assign bypass = empty & i_valid & ~i_flush;
`else
  assign bypass = 1'b0;
`endif

  assign o_valid = (~empty | bypass) & ~i_flush;
  assign pop     = o_valid & i_ready;

  // A bypassed instruction that decode takes immediately is neither written
  // nor popped; if decode stalls it, it lands in storage like any push.
  assign wr_en  = push & ~(bypass & i_ready);
  assign rd_adv = pop & ~bypass;

  // Head outputs
  always_comb begin
    o_instruction = instr_q[rd_ptr_q];
    o_pc          = pc_q[rd_ptr_q];
    o_pc_plus4    = pc4_q[rd_ptr_q];
`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
    if (bypass) begin
      o_instruction = i_instruction;
      o_pc          = i_pc;
      o_pc_plus4    = i_pc_plus4;
    end
`endif
  end

  // Pointer / occupancy next state
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en)  wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_adv) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_en, rd_adv})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage: cleared on reset, left untouched by flush (pointers alone
  // make stale entries invisible).
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
        pc4_q[i]   <= '0;
      end
    end else if (wr_en) begin
      instr_q[wr_ptr_q] <= i_instruction;
      pc_q[wr_ptr_q]    <= i_pc;
      pc4_q[wr_ptr_q]   <= i_pc_plus4;
    end
  end

  assign o_count = count_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// -----------------------------------------------------------------------------
// Testbench for fetch_decode_queue. A reference model at the rising edge keeps
// an occupancy count and appends every accepted instruction to an expected
// stream; a monitor at the falling edge checks handshake/occupancy outputs
// and pops the expected stream whenever decode takes the head entry.
// -----------------------------------------------------------------------------
module tb_fetch_decode_queue;

  localparam int AW = 64;
  localparam int IW = 32;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [IW-1:0] i_instruction = '0;
  logic [AW-1:0] i_pc = '0;
  logic [AW-1:0] i_pc_plus4 = '0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic          i_flush = 1'b0;
  logic [IW-1:0] o_instruction;
  logic [AW-1:0] o_pc;
  logic [AW-1:0] o_pc_plus4;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [CW-1:0] o_count;

  always #5 clk = ~clk;

  fetch_decode_queue #(
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(IW),
    .DEPTH      (D)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_instruction(i_instruction),
    .i_pc         (i_pc),
    .i_pc_plus4   (i_pc_plus4),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_flush      (i_flush),
    .o_instruction(o_instruction),
    .o_pc         (o_pc),
    .o_pc_plus4   (o_pc_plus4),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_count      (o_count)
  );

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc4;
  } ent_t;

  ent_t sb[$];       // expected output stream, oldest first
  int   occ   = 0;   // model occupancy after the last edge
  bit   armed = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: decides acceptance from the queue rules and records
  // what decode must see, in order.
  always @(posedge clk) begin : model
    bit byp;
    bit pu;
    bit po;
    if (!i_rst_n) begin
      occ = 0;
      sb.delete();
      armed = 1'b1;
    end else if (i_flush) begin
      occ = 0;
      sb.delete();
    end else begin
      byp = BYP && (occ == 0) && i_valid;
      if (!(byp && i_ready)) begin
        pu = i_valid && (occ != D);
        po = (occ != 0) && i_ready;
        if (pu) begin
          sb.push_back('{i_instruction, i_pc, i_pc_plus4});
          $display("push pc=%h occ_after=%0d", i_pc, occ + int'(pu) - int'(po));
        end
        occ = occ + int'(pu) - int'(po);
      end
    end
  end

  // Monitor: compares DUT outputs against the model between edges.
  always @(negedge clk) begin : monitor
    bit   byp;
    bit   ev;
    ent_t e;
    if (armed) begin
      byp = BYP && (occ == 0) && i_valid && !i_flush;
      ev  = ((occ != 0) || byp) && !i_flush;
      check("o_count", 64'(o_count), 64'(occ));
      check("o_ready", 64'(o_ready), 64'(occ != D));
      check("o_valid", 64'(o_valid), 64'(ev));
      if (ev) begin
        e = '0;
        if (byp) e = '{i_instruction, i_pc, i_pc_plus4};
        else if (sb.size() != 0) e = sb[0];
        else begin
          n_chk++;
          $display("FAIL scoreboard_empty: got valid head expected no entry");
        end
        check("o_instruction", 64'(o_instruction), 64'(e.instr));
        check("o_pc", o_pc, e.pc);
        check("o_pc_plus4", o_pc_plus4, e.pc4);
        if (i_ready) begin
          $display("pop pc=%h bypass=%0d", o_pc, byp);
          if (!byp && sb.size() != 0) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic cyc(input bit v, input logic [63:0] pc, input bit fl, input bit rd);
    i_valid       = v;
    i_pc          = pc;
    i_pc_plus4    = pc + 64'd4;
    i_instruction = $urandom;
    i_flush       = fl;
    i_ready       = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [63:0] pc;
    // Reset with fetch asserting valid: nothing may be captured.
    i_rst_n = 1'b0;
    i_valid = 1'b1;
    i_pc    = 64'h1234;
    i_pc_plus4 = 64'h1238;
    i_instruction = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1;
    i_valid = 1'b0;
    #1;
    check("rst_instruction", 64'(o_instruction), 64'h0);
    check("rst_pc", o_pc, 64'h0);
    check("rst_pc_plus4", o_pc_plus4, 64'h0);
    check("rst_valid", 64'(o_valid), 64'h0);
    i_rst_n = 1'b1;
    cyc(0, 0, 0, 0);

    // Streaming
    cyc(1, 64'h0, 0, 1);
    cyc(1, 64'h4, 0, 1);
    cyc(1, 64'h8, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    // Fill, overflow attempt, partial drain, refill across the wrap
    for (int i = 0; i < 4; i++) cyc(1, 64'h100 + 64'(4 * i), 0, 0);
    cyc(1, 64'h110, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 64'h110, 0, 0);
    cyc(1, 64'h114, 0, 0);
    repeat (5) cyc(0, 0, 0, 1);

    // Flush at occupancy 3 with a competing push and pop
    for (int i = 0; i < 3; i++) cyc(1, 64'h1F0 + 64'(4 * i), 0, 0);
    cyc(1, 64'h200, 1, 1);
    cyc(0, 0, 0, 1);

    // Simultaneous push/pop at occupancy 2
    cyc(1, 64'h400, 0, 0);
    cyc(1, 64'h404, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 64'h408 + 64'(4 * i), 0, 1);
    repeat (3) cyc(0, 0, 0, 1);

    // Empty queue: offer with decode ready, then with decode stalled
    cyc(1, 64'h300, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 64'h304, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    // Flush while empty
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);

    // Randomized phases with varying pressure
    pc = 64'h1000;
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 150; i++) begin
        bit v;
        bit rd;
        bit fl;
        v  = ($urandom_range(0, 3) != 0);
        rd = (ph == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
        fl = ($urandom_range(0, 24) == 0);
        cyc(v, pc, fl, rd);
        pc = pc + 64'd4;
      end
    end
    repeat (6) cyc(0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
